dpm_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that is the client of a double-ported memory block.
- Port A of the memory is used write-only (push side); port B is used read-only (pop side).
- Adds valid/ready streaming on both sides, pointer/occupancy tracking, and a 2-entry prefetch buffer that hides the memory's 1-cycle registered read latency.
- Sits between a producer stream and a consumer stream; the memory instance is external and connected port-to-port.

---
 rtl/dpm_fifo_ctrl_pkg.sv | 10 +
 rtl/dpm_fifo_ctrl_if.sv | 38 +++
 rtl/dpm_fifo_ctrl_obuf.sv | 43 ++++
 rtl/dpm_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_dpm_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpm_fifo_ctrl_pkg.sv
// dpm_fifo_ctrl shared constants: default widths and prefetch depth.
// Optional occupancy port is enabled with DPM_FIFO_LEVEL_EN.
package dpm_pkg;
  localparam int DPM_DW    = 8;
  localparam int DPM_AW    = 10;
  localparam int DPM_OBUF  = 2;
  localparam int DPM_PTR_W = DPM_AW;
  localparam int DPM_CNT_W = DPM_AW + 1;
  localparam int DPM_LVL_W = DPM_AW + 2;
endpackage

// File: rtl/dpm_fifo_ctrl_if.sv
// Stream and memory-port bundle for dpm_fifo_ctrl.
// master = controller side, slave = producer/consumer/memory side.
interface dpm_fifo_ctrl_if
  import dpm_pkg::*;
#(
  parameter int DW = DPM_DW,
  parameter int AW = DPM_AW
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] mem_addr_a;
  logic          mem_en_a;
  logic          mem_w_a;
  logic [DW-1:0] mem_in_a;
  logic [AW-1:0] mem_addr_b;
  logic          mem_en_b;
  logic          mem_w_b;
  logic [DW-1:0] mem_in_b;
  logic [DW-1:0] mem_out_b;

  modport master (
    input  in_valid, in_data, out_ready, mem_out_b,
    output in_ready, out_valid, out_data,
    output mem_addr_a, mem_en_a, mem_w_a, mem_in_a,
    output mem_addr_b, mem_en_b, mem_w_b, mem_in_b
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_out_b,
    input  in_ready, out_valid, out_data,
    input  mem_addr_a, mem_en_a, mem_w_a, mem_in_a,
    input  mem_addr_b, mem_en_b, mem_w_b, mem_in_b
  );
endinterface

// File: rtl/dpm_fifo_ctrl_obuf.sv
// Two-entry prefetch buffer; entry 0 is the head and drives o_data.
// The head register holds its last value while the buffer is empty.
module dpm_fifo_obuf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cap_valid,
  input  logic [DW-1:0] i_cap_data,
  input  logic          i_pop_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_cnt
);
  logic [DW-1:0] r_q0;
  logic [DW-1:0] r_q1;
  logic [1:0]    r_cnt;
  logic          w_pop;
  logic [1:0]    w_slot;

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_q0;
  assign o_cnt   = r_cnt;
  assign w_pop   = o_valid & i_pop_ready;
  assign w_slot  = r_cnt - {1'b0, w_pop};

  // Shift only when a second entry exists, so a lone head is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      if (w_pop && r_cnt == 2'd2)
        r_q0 <= r_q1;
      if (i_cap_valid && w_slot == 2'd0)
        r_q0 <= i_cap_data;
      if (i_cap_valid && w_slot == 2'd1)
        r_q1 <= i_cap_data;
      r_cnt <= w_slot + {1'b0, i_cap_valid};
    end
  end
endmodule

// File: rtl/dpm_fifo_ctrl.sv
// FIFO controller over a dual-port memory with a 2-deep read prefetch.
// Define DPM_FIFO_LEVEL_EN to add the registered occupancy port.
module dpm_fifo_ctrl
  import dpm_pkg::*;
#(
  parameter int DW = DPM_DW,
  parameter int AW = DPM_AW
) (
  input logic               clk,
  input logic               rst_n,
  dpm_fifo_ctrl_if.master   bus
`ifdef DPM_FIFO_LEVEL_EN
  ,
  output logic [AW+1:0]     level
`endif
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(1) << AW;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_mem_cnt;
  logic          r_inflight;
  logic          r_en_b;

  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [1:0]    w_ocnt;
  logic [2:0]    w_occ;
  logic [AW:0]   w_mem_cnt_nxt;

  assign bus.in_ready = r_en_b & (r_mem_cnt != DEPTH_C);
  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  assign bus.mem_en_a   = w_push;
  assign bus.mem_w_a    = w_push;
  assign bus.mem_addr_a = r_wr_ptr;
  assign bus.mem_in_a   = bus.in_data;

  assign bus.mem_addr_b = r_rd_ptr;
  assign bus.mem_en_b   = r_en_b;
  assign bus.mem_w_b    = 1'b0;
  assign bus.mem_in_b   = '0;

  // Occupancy of the prefetch path after this cycle's pop.
  assign w_occ = {1'b0, w_ocnt}
               + {2'b0, r_inflight}
               - {2'b0, w_pop};
  assign w_issue = (r_mem_cnt != '0)
                 & (w_occ < 3'(DPM_OBUF));

  assign w_mem_cnt_nxt = r_mem_cnt
                       + {{AW{1'b0}}, w_push}
                       - {{AW{1'b0}}, w_issue};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_en_b     <= 1'b0;
    end else begin
      r_en_b     <= 1'b1;
      r_mem_cnt  <= w_mem_cnt_nxt;
      r_inflight <= w_issue;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  dpm_fifo_obuf #(
    .DW(DW)
  ) u_obuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cap_valid(r_inflight),
    .i_cap_data (bus.mem_out_b),
    .i_pop_ready(bus.out_ready),
    .o_valid    (bus.out_valid),
    .o_data     (bus.out_data),
    .o_cnt      (w_ocnt)
  );

`ifdef DPM_FIFO_LEVEL_EN
  logic [1:0] w_ocnt_nxt;

  assign w_ocnt_nxt = w_ocnt
                    + {1'b0, r_inflight}
                    - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      level <= '0;
    else
      level <= {1'b0, w_mem_cnt_nxt}
             + (AW+2)'(w_issue)
             + (AW+2)'(w_ocnt_nxt);
  end
`endif
endmodule

// File: tb/tb_dpm_fifo_ctrl.sv
// Randomized bench for dpm_fifo_ctrl against a queue reference model.
// Includes a behavioural dual-port memory with registered port B.
module tb_dpm_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpm_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus();

`ifdef DPM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
`endif

  dpm_fifo_ctrl #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef DPM_FIFO_LEVEL_EN
    ,
    .level(level)
`endif
  );

  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (bus.mem_en_a && bus.mem_w_a)
      mem[bus.mem_addr_a] <= bus.mem_in_a;
    if (bus.mem_en_b)
      bus.mem_out_b <= mem[bus.mem_addr_b];
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];
  int wr_cnt = 0;
  int n_pop = 0;
  bit push;
  bit pop;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, score the handshakes.
  task automatic cyc(input bit iv,
                     input logic [DW-1:0] d,
                     input bit ordy);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    push = iv && bus.in_ready;
    pop  = bus.out_valid && ordy;
`ifdef DPM_FIFO_LEVEL_EN
    check("level_model", 32'(level), q.size());
`endif
    check("en_a", bus.mem_en_a, push);
    check("w_a", bus.mem_w_a, push);
    if (pop) begin
      check("pop_nonempty", q.size() > 0, 1);
      if (q.size() > 0)
        check("data", bus.out_data, q.pop_front());
      n_pop++;
    end
    if (push) begin
      check("addr_a", bus.mem_addr_a, wr_cnt % DEPTH);
      check("in_a", bus.mem_in_a, d);
      wr_cnt++;
      q.push_back(d);
    end
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (q.size() == 0) break;
      cyc(1'b0, '0, 1'b1);
    end
    check("drain_empty", q.size(), 0);
    cyc(1'b0, '0, 1'b1);
    check("drained_valid", bus.out_valid, 0);
  endtask

  task automatic wait_ready(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (bus.in_ready) break;
      cyc(1'b0, '0, 1'b0);
    end
    check("ready_timeout", bus.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int acc;
    int first;
    int bub;
    int p0;
    int last_a;
    bit ird_low;
    bit wrap;
    bit got;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_en_b", bus.mem_en_b, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_w_b", bus.mem_w_b, 0);
    check("rst_in_b", bus.mem_in_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0);
    check("en_b_up", bus.mem_en_b, 1);
    check("ready_up", bus.in_ready, 1);

    // Single word latency.
    cyc(1'b1, 8'hA5, 1'b1);
    check("lat_c0_push", push, 1);
    check("lat_c0_addr", bus.mem_addr_a, 0);
    check("lat_c0_valid", bus.out_valid, 0);
    cyc(1'b0, '0, 1'b1);
    check("lat_c1_addr_b", bus.mem_addr_b, 0);
    check("lat_c1_valid", bus.out_valid, 0);
    cyc(1'b0, '0, 1'b1);
    check("lat_c2_addr_b", bus.mem_addr_b, 1);
    check("lat_c2_valid", bus.out_valid, 0);
    cyc(1'b0, '0, 1'b1);
    check("lat_c3_valid", bus.out_valid, 1);
    check("lat_c3_data", bus.out_data, 8'hA5);
    cyc(1'b0, '0, 1'b1);
    check("lat_c4_valid", bus.out_valid, 0);

    // Back-to-back stream.
    first = -1;
    bub = 0;
    ird_low = 1'b0;
    p0 = n_pop;
    for (int i = 0; i < 25; i++) begin
      cyc(i < 16, 8'(i), 1'b1);
      if (!bus.in_ready) ird_low = 1'b1;
      if (first < 0 && bus.out_valid) first = i;
      else if (first >= 0 && n_pop - p0 < 16 && !bus.out_valid)
        bub++;
    end
    check("stream_first", first, 3);
    check("stream_bubbles", bub, 0);
    check("stream_pops", n_pop - p0, 16);
    check("stream_ready", ird_low, 0);

    // Fill to capacity with the consumer stalled.
    acc = 0;
    for (int k = 0; k < 1200; k++) begin
      cyc(1'b1, 8'(acc), 1'b0);
      if (push) acc++;
      else break;
    end
    check("fill_count", acc, DEPTH + 2);
    check("fill_ready", bus.in_ready, 0);
    cyc(1'b0, '0, 1'b1);
    check("unfill_pop", pop, 1);
    check("unfill_ready_t", bus.in_ready, 0);
    cyc(1'b0, '0, 1'b1);
    check("unfill_ready_t1", bus.in_ready, 1);
    drain(1200);

    // Pointer wrap with interleaved pops.
    acc = 0;
    wrap = 1'b0;
    last_a = -1;
    for (int k = 0; k < 5000 && acc < 1030; k++) begin
      cyc(1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
      if (push) begin
        if (last_a == DEPTH - 1 && bus.mem_addr_a == 0)
          wrap = 1'b1;
        last_a = int'(bus.mem_addr_a);
        acc++;
      end
    end
    check("wrap_pushes", acc, 1030);
    check("wrap_seen", wrap, 1);
    drain(1200);

    // Random traffic.
    for (int k = 0; k < 1500; k++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom),
          $urandom_range(0, 3) != 0);
    drain(1200);

    // Asynchronous reset with words buffered.
    for (int k = 0; k < 5; k++)
      cyc(1'b1, 8'(8'h50 + k), 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0);
    check("pre_rst_valid", bus.out_valid, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_ready", bus.in_ready, 0);
    check("arst_en_b", bus.mem_en_b, 0);
    check("arst_en_a", bus.mem_en_a, 0);
    q.delete();
    wr_cnt = 0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(4);
    cyc(1'b1, 8'h3C, 1'b1);
    check("post_rst_push", push, 1);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, '0, 1'b1);
      if (pop) begin
        got = 1'b1;
        break;
      end
    end
    check("post_rst_pop", got, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, '0, 1'b1);
      check("no_stale", bus.out_valid, 0);
    end

`ifdef DPM_FIFO_LEVEL_EN
    cyc(1'b1, 8'h11, 1'b0);
    check("lvl0", 32'(level), 0);
    cyc(1'b1, 8'h22, 1'b0);
    check("lvl1", 32'(level), 1);
    cyc(1'b1, 8'h33, 1'b0);
    check("lvl2", 32'(level), 2);
    cyc(1'b0, '0, 1'b0);
    check("lvl3", 32'(level), 3);
    repeat (5) cyc(1'b0, '0, 1'b0);
    check("lvl3_hold", 32'(level), 3);
    drain(20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
